sort_stream_n: RTL and testbench
================================

// Module: sort_stream_n
// PURPOSE
//  Serial-in/serial-out labelled sorter; generalises the fixed 4-input parallel sorting network
//  to NUM_INPUTS elements with valid/ready flow control on both sides.
//  Loads one (data,label) pair per accepted beat, sorts in place with odd-even transposition
//  (one compare-exchange stage per cycle), then streams the sorted frame out with y_last.
//  Sits between a sample source and a top-k/selection consumer that cannot accept wide parallel buses.
// PARAMETERS
//  NUM_INPUTS   8  elements per frame; >=2, need not be a power of 2
//  DATA_WIDTH   8  key width
//  LABEL_WIDTH  3  label width carried alongside each key
//  SIGNED       1  1: keys compared as two's complement; 0: unsigned
//  ASCENDING    0  1: first output smallest; 0: first output largest
// PORTS
//  clk        in   1            clock
//  rst        in   1            synchronous reset, active-high
//  x_valid    in   1            input beat valid
//  x_ready    out  1            input beat accepted when x_valid&&x_ready
//  x_data     in   DATA_WIDTH   input key
//  x_label    in   LABEL_WIDTH  input label
//  y_valid    out  1            output beat valid
//  y_ready    in   1            downstream accept
//  y_data     out  DATA_WIDTH   sorted key
//  y_label    out  LABEL_WIDTH  label travelling with y_data
//  y_last     out  1            high on final beat of a frame
//  busy       out  1            high in SORT or DRAIN
// BEHAVIOUR
//  Reset: one clk edge with rst=1 -> state LOAD, all counters 0, y_valid=0, y_last=0, busy=0,
//   storage contents don't-care; x_ready=0 while rst=1. Reset mid-frame discards the whole frame.
//  FSM LOAD->SORT->DRAIN->LOAD:
//   LOAD : x_ready=1; each handshake writes slot[load_cnt], load_cnt++; the edge accepting
//          element NUM_INPUTS-1 moves to SORT (stage_cnt=0). No combinational x_valid->x_ready path.
//   SORT : x_ready=0, y_valid=0; each edge applies stage stage_cnt: even stage pairs (0,1),(2,3)..,
//          odd stage pairs (1,2),(3,4)..; unpaired end slot holds. Swap only if strictly out of
//          order -> equal keys keep load order (stable). After stage NUM_INPUTS-1 -> DRAIN.
//   DRAIN: y_valid=1, y_data/y_label=slot[out_cnt] (registered storage, stable while stalled);
//          out_cnt++ on y_valid&&y_ready; y_last=(out_cnt==NUM_INPUTS-1); handshake on y_last
//          -> LOAD. x_valid ignored outside LOAD; y_ready ignored outside DRAIN.
//  Latency: last input accepted on edge E -> y_valid high after edge E+NUM_INPUTS; throughput
//   one frame per 2*NUM_INPUTS+NUM_INPUTS... cycles min (load N + sort N + drain N).
//  Compare: SIGNED selects $signed/$unsigned; order test uses full DATA_WIDTH, no truncation.
//  Counters: $clog2(NUM_INPUTS+1) bits; no wrap occurs inside a frame.
// CONFIGURATION
//  SORT_EARLY_EXIT_EN defined: per-stage swap flag; if two consecutive stages (one even, one odd)
//   perform no swap, SORT exits to DRAIN on that edge (minimum 2 stages). Output order identical.
//  Not defined: SORT always runs exactly NUM_INPUTS stages; no swap-flag logic synthesised.
// STRUCTURE
//  Package sort_stream_pkg: state enum {LOAD,SORT,DRAIN}, elem_t struct {data,label} builder,
//   function out_of_order(a,b,SIGNED,ASCENDING).
//  Sub-module sort_cmp_swap: combinational compare-exchange cell (a,b -> lo,hi,swapped), generated
//   floor(NUM_INPUTS/2) times per parity; storage, counters and FSM remain in sort_stream_n.
// TESTING (defaults unless stated)
//  1 keys 3,-1,7,0,7,-128,127,2 labels 0..7 -> y 127/6,7/2,7/4,3/0,2/7,0/3,-1/1,-128/5, y_last on 8th.
//  2 E = edge of last accept -> y_valid low through edge E+7, high after E+8 (macro off);
//    already-descending frame with SORT_EARLY_EXIT_EN -> y_valid high after E+2.
//  3 SIGNED=0,ASCENDING=1, keys 0x80,0x01,0xFF,0x00.. -> 0x00,0x01,..,0x80,..,0xFF (0x80 = 128).
//  4 y_ready toggled 1-in-3 during DRAIN -> y_data/y_label held while stalled, no beat lost/dup;
//    x_valid=1 throughout SORT/DRAIN -> x_ready=0, no element captured.
//  5 rst pulsed in SORT mid-frame -> next cycle busy=0, x_ready=1; fresh frame sorts correctly.
//  6 NUM_INPUTS=5, keys 1,2,3,4,5 descending -> 5,4,3,2,1; unpaired slot 4 untouched on even stages.

Source files
------------

// File: rtl/sort_stream_pkg.sv
// Shared types and key-ordering helpers for the streaming odd-even transposition sorter.
// Keys are widened to KEY_MAX_W bits before comparison so one helper serves every key width.
package sort_stream_pkg;

    localparam int KEY_MAX_W = 64;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Widen a raw key of 'width' bits (already zero-extended) to KEY_MAX_W, sign-extending when asked.
    function automatic logic [KEY_MAX_W-1:0] extend_key(
        input logic [KEY_MAX_W-1:0] raw,
        input int                   width,
        input logic                 is_signed
    );
        logic [KEY_MAX_W-1:0] upper_mask;
        upper_mask = ~((64'd1 << width) - 64'd1);
        if (is_signed && raw[width-1]) begin
            return raw | upper_mask;
        end else begin
            return raw & ~upper_mask;
        end
    endfunction

    // True when a (earlier slot) must move behind b; equal keys never swap, which keeps the sort stable.
    function automatic logic out_of_order(
        input logic [KEY_MAX_W-1:0] a,
        input logic [KEY_MAX_W-1:0] b,
        input logic                 is_signed,
        input logic                 ascending
    );
        logic a_gt_b;
        logic b_gt_a;
        if (is_signed) begin
            a_gt_b = $signed(a) > $signed(b);
            b_gt_a = $signed(b) > $signed(a);
        end else begin
            a_gt_b = a > b;
            b_gt_a = b > a;
        end
        if (ascending) begin
            return a_gt_b;
        end else begin
            return b_gt_a;
        end
    endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// Combinational compare-exchange cell on packed {key,label} elements.
// The swapped flag exists only when SORT_EARLY_EXIT_EN is defined.
module sort_cmp_swap
    import sort_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int LABEL_WIDTH = 3,
    parameter int SIGNED      = 1,
    parameter int ASCENDING   = 0
) (
    input  logic [DATA_WIDTH+LABEL_WIDTH-1:0] a,
    input  logic [DATA_WIDTH+LABEL_WIDTH-1:0] b,
    output logic [DATA_WIDTH+LABEL_WIDTH-1:0] lo,
    output logic [DATA_WIDTH+LABEL_WIDTH-1:0] hi
`ifdef SORT_EARLY_EXIT_EN
    ,
    output logic                              swapped
`endif
);

    localparam int EW = DATA_WIDTH + LABEL_WIDTH;

    logic [KEY_MAX_W-1:0] a_key_s;
    logic [KEY_MAX_W-1:0] b_key_s;
    logic                 swap_s;

    // Order test on the full-width keys, then route the pair accordingly.
    always_comb begin
        a_key_s = extend_key(KEY_MAX_W'(a[EW-1:LABEL_WIDTH]), DATA_WIDTH, SIGNED != 0);
        b_key_s = extend_key(KEY_MAX_W'(b[EW-1:LABEL_WIDTH]), DATA_WIDTH, SIGNED != 0);
        swap_s  = out_of_order(a_key_s, b_key_s, SIGNED != 0, ASCENDING != 0);
        if (swap_s) begin
            lo = b;
            hi = a;
        end else begin
            lo = a;
            hi = b;
        end
    end

`ifdef SORT_EARLY_EXIT_EN
    assign swapped = swap_s;
`endif

endmodule

// File: rtl/sort_stream_n.sv
// Serial-in/serial-out labelled sorter: load N beats, N odd-even transposition stages, drain N beats.
// Optional macro SORT_EARLY_EXIT_EN ends SORT after an even and an odd stage in a row do no swap.
module sort_stream_n
    import sort_stream_pkg::*;
#(
    parameter int NUM_INPUTS  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int LABEL_WIDTH = 3,
    parameter int SIGNED      = 1,
    parameter int ASCENDING   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   x_valid,
    output logic                   x_ready,
    input  logic [DATA_WIDTH-1:0]  x_data,
    input  logic [LABEL_WIDTH-1:0] x_label,
    output logic                   y_valid,
    input  logic                   y_ready,
    output logic [DATA_WIDTH-1:0]  y_data,
    output logic [LABEL_WIDTH-1:0] y_label,
    output logic                   y_last,
    output logic                   busy
);

    localparam int CW  = $clog2(NUM_INPUTS + 1);
    localparam int IW  = (NUM_INPUTS > 2) ? $clog2(NUM_INPUTS) : 1;
    localparam int NPE = NUM_INPUTS / 2;
    localparam int NPO = (NUM_INPUTS - 1) / 2;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  data;
        logic [LABEL_WIDTH-1:0] label;
    } elem_t;

    state_t          state_r;
    elem_t           slot_r  [NUM_INPUTS];
    elem_t           even_s  [NUM_INPUTS];
    elem_t           odd_s   [NUM_INPUTS];
    elem_t           stage_s [NUM_INPUTS];
    elem_t           y_elem_r;
    logic [CW-1:0]   load_cnt_r;
    logic [CW-1:0]   stage_cnt_r;
    logic [CW-1:0]   out_cnt_r;
    logic [CW-1:0]   out_nxt_s;
    logic [IW-1:0]   load_idx_s;
    logic [IW-1:0]   out_nxt_idx_s;
    logic            x_ready_r;
    logic            y_valid_r;
    logic            y_last_r;
    logic            busy_r;
    logic            x_fire_s;
    logic            y_fire_s;
    logic            sort_done_s;

`ifdef SORT_EARLY_EXIT_EN
    logic [NUM_INPUTS-1:0] even_swap_s;
    logic [NUM_INPUTS-1:0] odd_swap_s;
    logic                  stage_swap_s;
    logic                  prev_swap_r;
`endif

    genvar gi;

    // Even stage: pairs (0,1),(2,3)..; an odd element count leaves the top slot unpaired.
    generate
        for (gi = 0; gi < NPE; gi++) begin : g_even
            sort_cmp_swap #(
                .DATA_WIDTH (DATA_WIDTH),
                .LABEL_WIDTH(LABEL_WIDTH),
                .SIGNED     (SIGNED),
                .ASCENDING  (ASCENDING)
            ) u_cmp (
                .a      (slot_r[2*gi]),
                .b      (slot_r[2*gi+1]),
                .lo     (even_s[2*gi]),
                .hi     (even_s[2*gi+1])
`ifdef SORT_EARLY_EXIT_EN
                ,
                .swapped(even_swap_s[gi])
`endif
            );
        end
        if (NUM_INPUTS % 2 == 1) begin : g_even_tail
            assign even_s[NUM_INPUTS-1] = slot_r[NUM_INPUTS-1];
        end
`ifdef SORT_EARLY_EXIT_EN
        assign even_swap_s[NUM_INPUTS-1:NPE] = '0;
`endif
    endgenerate

    // Odd stage: pairs (1,2),(3,4)..; slot 0 always holds, the top slot holds for even counts.
    assign odd_s[0] = slot_r[0];
    generate
        for (gi = 0; gi < NPO; gi++) begin : g_odd
            sort_cmp_swap #(
                .DATA_WIDTH (DATA_WIDTH),
                .LABEL_WIDTH(LABEL_WIDTH),
                .SIGNED     (SIGNED),
                .ASCENDING  (ASCENDING)
            ) u_cmp (
                .a      (slot_r[2*gi+1]),
                .b      (slot_r[2*gi+2]),
                .lo     (odd_s[2*gi+1]),
                .hi     (odd_s[2*gi+2])
`ifdef SORT_EARLY_EXIT_EN
                ,
                .swapped(odd_swap_s[gi])
`endif
            );
        end
        if (NUM_INPUTS % 2 == 0) begin : g_odd_tail
            assign odd_s[NUM_INPUTS-1] = slot_r[NUM_INPUTS-1];
        end
`ifdef SORT_EARLY_EXIT_EN
        assign odd_swap_s[NUM_INPUTS-1:NPO] = '0;
`endif
    endgenerate

    assign x_fire_s      = (state_r == LOAD) && x_valid && x_ready;
    assign y_fire_s      = (state_r == DRAIN) && y_valid_r && y_ready;
    assign load_idx_s    = load_cnt_r[IW-1:0];
    assign out_nxt_s     = out_cnt_r + CW'(1);
    assign out_nxt_idx_s = out_nxt_s[IW-1:0];

    // Stage selection by counter parity and end-of-sort decision.
    always_comb begin
        if (stage_cnt_r[0]) begin
            stage_s = odd_s;
        end else begin
            stage_s = even_s;
        end
`ifdef SORT_EARLY_EXIT_EN
        if (stage_cnt_r[0]) begin
            stage_swap_s = |odd_swap_s;
        end else begin
            stage_swap_s = |even_swap_s;
        end
        sort_done_s = (stage_cnt_r == CW'(NUM_INPUTS - 1)) ||
                      ((stage_cnt_r != CW'(0)) && !prev_swap_r && !stage_swap_s);
`else
        sort_done_s = (stage_cnt_r == CW'(NUM_INPUTS - 1));
`endif
    end

    // Element storage: written by input beats in LOAD and by each stage in SORT; contents need no reset.
    always_ff @(posedge clk) begin
        if (x_fire_s) begin
            slot_r[load_idx_s] <= '{data: x_data, label: x_label};
        end else if (state_r == SORT) begin
            slot_r <= stage_s;
        end
    end

    // Control FSM with registered handshake and output beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= LOAD;
            load_cnt_r  <= '0;
            stage_cnt_r <= '0;
            out_cnt_r   <= '0;
            x_ready_r   <= 1'b1;
            y_valid_r   <= 1'b0;
            y_last_r    <= 1'b0;
            busy_r      <= 1'b0;
            y_elem_r    <= '0;
`ifdef SORT_EARLY_EXIT_EN
            prev_swap_r <= 1'b1;
`endif
        end else begin
            case (state_r)
                LOAD: begin
                    if (x_fire_s) begin
                        if (load_cnt_r == CW'(NUM_INPUTS - 1)) begin
                            state_r     <= SORT;
                            load_cnt_r  <= '0;
                            stage_cnt_r <= '0;
                            x_ready_r   <= 1'b0;
                            busy_r      <= 1'b1;
`ifdef SORT_EARLY_EXIT_EN
                            prev_swap_r <= 1'b1;
`endif
                        end else begin
                            load_cnt_r <= load_cnt_r + CW'(1);
                        end
                    end
                end
                SORT: begin
`ifdef SORT_EARLY_EXIT_EN
                    prev_swap_r <= stage_swap_s;
`endif
                    if (sort_done_s) begin
                        state_r     <= DRAIN;
                        stage_cnt_r <= '0;
                        out_cnt_r   <= '0;
                        y_valid_r   <= 1'b1;
                        y_last_r    <= 1'b0;
                        y_elem_r    <= stage_s[0];
                    end else begin
                        stage_cnt_r <= stage_cnt_r + CW'(1);
                    end
                end
                DRAIN: begin
                    if (y_fire_s) begin
                        if (y_last_r) begin
                            state_r   <= LOAD;
                            out_cnt_r <= '0;
                            x_ready_r <= 1'b1;
                            y_valid_r <= 1'b0;
                            y_last_r  <= 1'b0;
                            busy_r    <= 1'b0;
                        end else begin
                            out_cnt_r <= out_nxt_s;
                            y_last_r  <= (out_nxt_s == CW'(NUM_INPUTS - 1));
                            y_elem_r  <= slot_r[out_nxt_idx_s];
                        end
                    end
                end
                default: begin
                    state_r   <= LOAD;
                    x_ready_r <= 1'b1;
                    y_valid_r <= 1'b0;
                    y_last_r  <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign x_ready = x_ready_r & ~rst;
    assign y_valid = y_valid_r;
    assign y_data  = y_elem_r.data;
    assign y_label = y_elem_r.label;
    assign y_last  = y_last_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_sort_stream_n.sv
// Directed bench for sort_stream_n: three configurations (default, unsigned ascending, five elements).
// Expected latency follows SORT_EARLY_EXIT_EN when that macro is defined for the build.
module tb_sort_stream_n;

    logic       clk = 1'b0;
    logic       rst;
    logic       xv    [3];
    logic       xr    [3];
    logic [7:0] xd    [3];
    logic [2:0] xl    [3];
    logic       yv    [3];
    logic       yr    [3];
    logic [7:0] yd    [3];
    logic [2:0] yl    [3];
    logic       ylast [3];
    logic       bsy   [3];
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    sort_stream_n dut0 (
        .clk(clk), .rst(rst), .x_valid(xv[0]), .x_ready(xr[0]), .x_data(xd[0]), .x_label(xl[0]),
        .y_valid(yv[0]), .y_ready(yr[0]), .y_data(yd[0]), .y_label(yl[0]), .y_last(ylast[0]), .busy(bsy[0])
    );

    sort_stream_n #(.SIGNED(0), .ASCENDING(1)) dut1 (
        .clk(clk), .rst(rst), .x_valid(xv[1]), .x_ready(xr[1]), .x_data(xd[1]), .x_label(xl[1]),
        .y_valid(yv[1]), .y_ready(yr[1]), .y_data(yd[1]), .y_label(yl[1]), .y_last(ylast[1]), .busy(bsy[1])
    );

    sort_stream_n #(.NUM_INPUTS(5)) dut2 (
        .clk(clk), .rst(rst), .x_valid(xv[2]), .x_ready(xr[2]), .x_data(xd[2]), .x_label(xl[2]),
        .y_valid(yv[2]), .y_ready(yr[2]), .y_data(yd[2]), .y_label(yl[2]), .y_last(ylast[2]), .busy(bsy[2])
    );

    task automatic load_frame(input int d, input int n, input logic [7:0] k [8], input logic [2:0] l [8]);
        int wait_cnt;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            xv[d] = 1'b1;
            xd[d] = k[i];
            xl[d] = l[i];
            wait_cnt = 0;
            while (!xr[d] && wait_cnt < 50) begin
                @(negedge clk);
                wait_cnt++;
            end
            checks++;
            if (xr[d] !== 1'b1) begin
                failures++;
                $display("FAIL load_timeout dut%0d elem %0d: x_ready=%b required 1", d, i, xr[d]);
            end
            @(posedge clk);
        end
        @(negedge clk);
        xv[d] = 1'b0;
    endtask

    task automatic drain_check(input int d, input int n, input logic [7:0] ek [8], input logic [2:0] el [8],
                               input bit stall, input string nm);
        int         got  = 0;
        int         cyc  = 0;
        logic       held = 1'b0;
        logic [7:0] hd;
        logic [2:0] hl;
        while (got < n && cyc < 300) begin
            @(negedge clk);
            if (xv[d]) begin
                checks++;
                if (xr[d] !== 1'b0) begin
                    failures++;
                    $display("FAIL %s x_ready_busy cyc %0d: x_ready=%b required 0", nm, cyc, xr[d]);
                end
            end
            if (held) begin
                checks++;
                if ({yd[d], yl[d]} !== {hd, hl}) begin
                    failures++;
                    $display("FAIL %s stall_hold: y=%h/%0d required %h/%0d", nm, yd[d], yl[d], hd, hl);
                end
            end
            yr[d] = stall ? (cyc % 3 == 2) : 1'b1;
            held  = yv[d] && !yr[d];
            hd    = yd[d];
            hl    = yl[d];
            if (yv[d] && yr[d]) begin
                checks++;
                if ({yd[d], yl[d]} !== {ek[got], el[got]}) begin
                    failures++;
                    $display("FAIL %s beat %0d: y=%h/%0d required %h/%0d", nm, got, yd[d], yl[d], ek[got], el[got]);
                end
                checks++;
                if (ylast[d] !== (got == n - 1)) begin
                    failures++;
                    $display("FAIL %s y_last beat %0d: y_last=%b required %b", nm, got, ylast[d], got == n - 1);
                end
                if (got == n - 1) xv[d] = 1'b0;
                got++;
            end
            cyc++;
        end
        checks++;
        if (got != n) begin
            failures++;
            $display("FAIL %s drain_timeout: beats=%0d required %0d", nm, got, n);
        end
        @(negedge clk);
        yr[d] = 1'b0;
        checks++;
        if ({yv[d], bsy[d], xr[d]} !== 3'b001) begin
            failures++;
            $display("FAIL %s after_frame: valid/busy/ready=%b%b%b required 001", nm, yv[d], bsy[d], xr[d]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (xr[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_ready_low dut%0d: x_ready=%b required 0", d, xr[d]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({yv[d], ylast[d], bsy[d], xr[d]} !== 4'b0001) begin
                failures++;
                $display("FAIL reset_state dut%0d: valid/last/busy/ready=%b%b%b%b required 0001",
                         d, yv[d], ylast[d], bsy[d], xr[d]);
            end
        end
    endtask

    task automatic test_signed_desc();
        logic [7:0] k [8] = '{8'h03, 8'hFF, 8'h07, 8'h00, 8'h07, 8'h80, 8'h7F, 8'h02};
        logic [2:0] l [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [7:0] ek [8] = '{8'h7F, 8'h07, 8'h07, 8'h03, 8'h02, 8'h00, 8'hFF, 8'h80};
        logic [2:0] el [8] = '{3'd6, 3'd2, 3'd4, 3'd0, 3'd7, 3'd3, 3'd1, 3'd5};
        load_frame(0, 8, k, l);
        drain_check(0, 8, ek, el, 1'b0, "signed_desc");
    endtask

    task automatic test_latency();
        logic [7:0] k [8] = '{8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20};
        logic [2:0] l [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        int lat;
`ifdef SORT_EARLY_EXIT_EN
        lat = 2;
`else
        lat = 8;
`endif
        load_frame(0, 8, k, l);
        for (int s = 1; s <= 8; s++) begin
            @(negedge clk);
            checks++;
            if (yv[0] !== (s >= lat)) begin
                failures++;
                $display("FAIL latency edge E+%0d: y_valid=%b required %b", s, yv[0], s >= lat);
            end
        end
        drain_check(0, 8, k, l, 1'b0, "latency_frame");
    endtask

    task automatic test_unsigned_asc();
        logic [7:0] k [8] = '{8'h80, 8'h01, 8'hFF, 8'h00, 8'h7F, 8'h10, 8'hFE, 8'h02};
        logic [2:0] l [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [7:0] ek [8] = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h7F, 8'h80, 8'hFE, 8'hFF};
        logic [2:0] el [8] = '{3'd3, 3'd1, 3'd7, 3'd5, 3'd4, 3'd0, 3'd6, 3'd2};
        load_frame(1, 8, k, l);
        drain_check(1, 8, ek, el, 1'b0, "unsigned_asc");
    endtask

    task automatic test_stall_and_ignore();
        logic [7:0] k [8] = '{8'h11, 8'h44, 8'h22, 8'h44, 8'h33, 8'h00, 8'hC0, 8'h55};
        logic [2:0] l [8] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        logic [7:0] ek [8] = '{8'h55, 8'h44, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00, 8'hC0};
        logic [2:0] el [8] = '{3'd0, 3'd6, 3'd4, 3'd3, 3'd5, 3'd7, 3'd2, 3'd1};
        load_frame(0, 8, k, l);
        xv[0] = 1'b1;
        xd[0] = 8'h66;
        xl[0] = 3'd5;
        drain_check(0, 8, ek, el, 1'b1, "stall_drain");
    endtask

    task automatic test_reset_mid_sort();
        logic [7:0] k [8] = '{8'h03, 8'hFF, 8'h07, 8'h00, 8'h07, 8'h80, 8'h7F, 8'h02};
        logic [2:0] l [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [7:0] k2 [8] = '{8'h10, 8'h20, 8'hF0, 8'h20, 8'h05, 8'h00, 8'h7F, 8'h81};
        logic [7:0] ek [8] = '{8'h7F, 8'h20, 8'h20, 8'h10, 8'h05, 8'h00, 8'hF0, 8'h81};
        logic [2:0] el [8] = '{3'd6, 3'd1, 3'd3, 3'd0, 3'd4, 3'd5, 3'd2, 3'd7};
        load_frame(0, 8, k, l);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (xr[0] !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_ready_low: x_ready=%b required 0", xr[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({bsy[0], xr[0], yv[0]} !== 3'b010) begin
            failures++;
            $display("FAIL mid_reset_state: busy/ready/valid=%b%b%b required 010", bsy[0], xr[0], yv[0]);
        end
        load_frame(0, 8, k2, l);
        drain_check(0, 8, ek, el, 1'b0, "after_mid_reset");
    endtask

    task automatic test_five_elems();
        logic [7:0] k [8]  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd0, 8'd0};
        logic [2:0] l [8]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0, 3'd0};
        logic [7:0] ek [8] = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
        logic [2:0] el [8] = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
        logic [7:0] k2 [8] = '{8'd2, 8'd2, 8'd9, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
        logic [7:0] ek2 [8] = '{8'd9, 8'd2, 8'd2, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
        logic [2:0] el2 [8] = '{3'd2, 3'd0, 3'd1, 3'd3, 3'd4, 3'd0, 3'd0, 3'd0};
        load_frame(2, 5, k, l);
        drain_check(2, 5, ek, el, 1'b0, "five_rev");
        load_frame(2, 5, k2, l);
        drain_check(2, 5, ek2, el2, 1'b0, "five_dups");
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            xv[d] = 1'b0;
            yr[d] = 1'b0;
            xd[d] = 8'h00;
            xl[d] = 3'd0;
        end
        test_reset();
        test_signed_desc();
        test_latency();
        test_unsigned_asc();
        test_stall_and_ignore();
        test_signed_desc();
        test_reset_mid_sort();
        test_five_elems();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
